ps2_host_tx: RTL
================

// Module: ps2_host_tx
// PURPOSE
//  PS/2 host-to-device transmitter; the sending end of the PS/2 link whose receive side feeds mouse positions.
//  Sends one command byte to the mouse (e.g. 0xF4 enable reporting, 0xFF reset) over the shared ps2_clk/ps2_data lines.
//  Drives the open-drain pads at top level: pad = oe ? 1'b0 : 1'bz. The mouse receiver keeps sampling the same pads.
// PARAMETERS
//  INHIBIT_CYCLES  6500     clk cycles ps2_clk is held low before the request (>=100 us at clk rate)
//  TIMEOUT_CYCLES  1300000  max clk cycles from end of INHIBIT to ack completion (~20 ms)
//  MAX_RETRIES     2        extra attempts after NACK/timeout; used only with PS2_TX_RETRY_EN
// PORTS
//  clk          in   1  system clock
//  rst          in   1  synchronous reset, active high
//  ps2_clk_i    in   1  ps2_clk pad value (asynchronous)
//  ps2_data_i   in   1  ps2_data pad value (asynchronous)
//  ps2_clk_oe   out  1  1 = pull ps2_clk low
//  ps2_data_oe  out  1  1 = pull ps2_data low
//  tx_data      in   8  command byte
//  tx_valid     in   1  request; accepted when tx_valid && tx_ready
//  tx_ready     out  1  high only in IDLE
//  busy         out  1  high in every state except IDLE
//  done         out  1  1-cycle pulse: byte acked and lines idle
//  err          out  1  1-cycle pulse: NACK or timeout; final after retries
// BEHAVIOUR
//  - Reset: state IDLE; ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, busy=0, done=0, err=0; counters and synchronizers cleared.
//  - Reset mid-transfer releases both lines on the next clk edge. No done or err pulse is issued.
//  - Each input passes a 2-FF synchronizer. fall = sync_clk_q & ~sync_clk (one clk after synced 1->0).
//  - Accept: latch tx_data; shift reg = {stop=1, parity=~^tx_data, tx_data}, LSB first. Enter INHIBIT on the next cycle.
//  - tx_valid while busy is ignored; nothing is queued.
//  - FSM:
//    IDLE    -> INHIBIT on accept.
//    INHIBIT: clk_oe=1, data_oe=0 for INHIBIT_CYCLES.
//             Last cycle sets data_oe=1 (start bit).
//             Next cycle: clk_oe=0 -> REQ. Timeout counter starts.
//    REQ:     clk released, data_oe=1. On first fall -> SHIFT, drive bit0 (data_oe = ~bit).
//    SHIFT:   on each fall, present next bit; bit_cnt 0..9 (8 data, parity, stop).
//             Stop bit (data_oe=0) is presented on the 10th fall -> ACK.
//    ACK:     on next fall sample sync_data.
//             0 -> WAIT_IDLE. 1 -> NACK (err path).
//    WAIT_IDLE: both synced lines high for 1 cycle -> done pulse, -> IDLE.
//  - Timeout counter saturates. On reaching TIMEOUT_CYCLES in REQ/SHIFT/ACK/WAIT_IDLE:
//    release both lines, err path.
//  - err path without retry: err=1 for 1 cycle, -> IDLE.
//  - done and err are never high together. tx_ready rises the cycle after done/err.
//  - Bit counter 4 bits, no wrap: the fall after the stop bit is always the ACK sample.
// CONFIGURATION
//  PS2_TX_RETRY_EN defined:
//    NACK or timeout with attempt count < MAX_RETRIES: increment count, re-enter INHIBIT with the same latched byte.
//    No err pulse on retry.
//    err pulses only after attempt MAX_RETRIES+1 fails. busy stays high throughout.
//  PS2_TX_RETRY_EN undefined:
//    Every failure pulses err immediately. MAX_RETRIES is ignored. No attempt counter exists.
// TESTING
//  Bench parameters: INHIBIT_CYCLES=8, TIMEOUT_CYCLES=4000.
//  Device model: 40-cycle clk period, samples on rise, drives ack.
//  - tx_data=0xF4 -> clk_oe high exactly 8 cycles. Device reads start 0, bits 0,0,1,0,1,1,1,1, parity 0, stop 1.
//    ack=0 -> done 1 cycle, err 0.
//  - tx_data=0x00 -> parity bit 1, stop 1. Acked -> done.
//  - Device answers ack=1 (no define) -> err 1 cycle, done 0, both oe=0, tx_ready=1 next cycle.
//  - No device clocks -> err exactly TIMEOUT_CYCLES after REQ entry.
//    With PS2_TX_RETRY_EN: 3 INHIBIT phases, then a single err.
//  - rst asserted after 4th data bit -> next cycle oe=0/0, tx_ready=1.
//    New 0xFF then completes with done.
//  - tx_valid pulsed with 0xAA during busy of 0xF4 -> ignored. Only 0xF4 is observed, one done.

Source files
------------

// File: rtl/ps2_host_tx_if.sv
// Command-side handshake bundle for the PS/2 host transmitter.
// master = command source, slave = ps2_host_tx.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  busy,
        input  done,
        input  err
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output busy,
        output done,
        output err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter driving open-drain enables for ps2_clk/ps2_data.
// Define PS2_TX_RETRY_EN to re-send the latched byte after NACK/timeout up to MAX_RETRIES times.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 6500,
    parameter int unsigned TIMEOUT_CYCLES = 1300000,
    parameter int unsigned MAX_RETRIES    = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ps2_clk_i,
    input  logic         ps2_data_i,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe,
    ps2_host_tx_if.slave tx
);
    localparam int unsigned InhW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StReq,
        StShift,
        StAck,
        StWaitIdle
    } state_e;

    state_e          state_q, state_d;
    logic [InhW-1:0] inh_cnt_q, inh_cnt_d;
    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [9:0]      shift_q, shift_d;
    logic            clk_meta_q, clk_sync_q, clk_prev_q;
    logic            data_meta_q, data_sync_q;
    logic            idle, accept, fall, timeout, fail;
    logic            done_pulse, err_pulse;

`ifdef PS2_TX_RETRY_EN
    localparam int unsigned AttW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    logic [AttW-1:0] attempt_q, attempt_d;
    logic [7:0]      byte_q, byte_d;
`else
    logic unused_max_retries;
    assign unused_max_retries = ^MAX_RETRIES;
`endif

    assign idle        = (state_q == StIdle);
    assign accept      = tx.tx_valid & idle;
    assign fall        = clk_prev_q & ~clk_sync_q;
    assign timeout     = (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES));
    assign tx.tx_ready = idle;
    assign tx.busy     = ~idle;
    assign tx.done     = done_pulse;
    assign tx.err      = err_pulse;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_meta_q  <= 1'b0;
            clk_sync_q  <= 1'b0;
            clk_prev_q  <= 1'b0;
            data_meta_q <= 1'b0;
            data_sync_q <= 1'b0;
            state_q     <= StIdle;
            inh_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
`ifdef PS2_TX_RETRY_EN
            attempt_q   <= '0;
            byte_q      <= '0;
`endif
        end else begin
            clk_meta_q  <= ps2_clk_i;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps2_data_i;
            data_sync_q <= data_meta_q;
            state_q     <= state_d;
            inh_cnt_q   <= inh_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
`ifdef PS2_TX_RETRY_EN
            attempt_q   <= attempt_d;
            byte_q      <= byte_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        inh_cnt_d   = inh_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        done_pulse  = 1'b0;
        err_pulse   = 1'b0;
        fail        = 1'b0;
`ifdef PS2_TX_RETRY_EN
        attempt_d   = attempt_q;
        byte_d      = byte_q;
`endif
        // Saturating ack-window counter, live from REQ entry until the transfer ends.
        if ((state_q inside {StReq, StShift, StAck, StWaitIdle}) && !timeout) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    shift_d   = {1'b1, ~^tx.tx_data, tx.tx_data};
                    inh_cnt_d = '0;
                    state_d   = StInhibit;
`ifdef PS2_TX_RETRY_EN
                    attempt_d = '0;
                    byte_d    = tx.tx_data;
`endif
                end
            end
            StInhibit: begin
                ps2_clk_oe = 1'b1;
                tmo_cnt_d  = '0;
                bit_cnt_d  = '0;
                if (inh_cnt_q == InhW'(INHIBIT_CYCLES - 1)) begin
                    ps2_data_oe = 1'b1;
                    state_d     = StReq;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end
            StReq: begin
                if (timeout) begin
                    fail = 1'b1;
                end else begin
                    ps2_data_oe = 1'b1;
                    if (fall) state_d = StShift;
                end
            end
            StShift: begin
                if (timeout) begin
                    fail = 1'b1;
                end else begin
                    ps2_data_oe = ~shift_q[0];
                    if (fall) begin
                        shift_d   = {1'b0, shift_q[9:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        // Fall after parity presents the stop bit, which is a released line.
                        if (bit_cnt_q == 4'd8) state_d = StAck;
                    end
                end
            end
            StAck: begin
                if (timeout) begin
                    fail = 1'b1;
                end else if (fall) begin
                    if (data_sync_q) fail = 1'b1;
                    else             state_d = StWaitIdle;
                end
            end
            StWaitIdle: begin
                if (timeout) begin
                    fail = 1'b1;
                end else if (clk_sync_q && data_sync_q) begin
                    done_pulse = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (fail) begin
`ifdef PS2_TX_RETRY_EN
            if (attempt_q < AttW'(MAX_RETRIES)) begin
                attempt_d = attempt_q + 1'b1;
                inh_cnt_d = '0;
                shift_d   = {1'b1, ~^byte_q, byte_q};
                state_d   = StInhibit;
            end else begin
                err_pulse = 1'b1;
                state_d   = StIdle;
            end
`else
            err_pulse = 1'b1;
            state_d   = StIdle;
`endif
        end
    end
endmodule
